irq_sequencer: RTL
==================

# irq_sequencer

Interrupt entry/exit controller for the banked register file. It watches the interrupt request line, sequences the banked-register backup (r0 ← interrupt ID, r13/r14 ← stack pointer and return address), and redirects fetch to the vector with a pipeline flush. It then holds the register file in interrupt mode until the handler signals return, and restores user mode with a flush and a jump to the saved return address.

## Interface
- `VECTOR`, default 32'h0000_0018: handler entry address.
- `ID_W`, default 8: interrupt ID width; zero-extended into r0.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  pipeline advance; the same signal as the register file `en`. The FSM only moves on cycles where it is high.
- `i_irq`  in  1  level interrupt request; held until `o_irq_ack`.
- `i_irq_id`  in  ID_W  ID of the requesting source; sampled in SAVE.
- `i_irq_enable`  in  1  global interrupt mask (1 = allowed).
- `i_pc_en`  in  1  a PC write is in flight this cycle (register file `o_pc_en`).
- `i_irq_ret`  in  1  handler return instruction retired; 1-cycle pulse.
- `i_ret_addr`  in  32  return address (banked r14 read); sampled with `i_irq_ret`.
- `o_int_mode`  out  1  to register file `i_int_mode`.
- `o_irq_bak`  out  2  to register file `i_irq_bak`.
- `o_irq_r0`  out  32  to register file `i_irq_r0`.
- `o_pc_load`  out  1  force PC to `o_pc_target`.
- `o_pc_target`  out  32  redirect address.
- `o_flush`  out  1  kill younger in-flight instructions.
- `o_irq_ack`  out  1  1-cycle acknowledge to the source.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, SAVE, LINK, ENTER, HANDLER, LEAVE. State is 3-bit registered and all transitions are gated by `i_en`. A stalled pipeline (`i_en`=0) freezes the state and all registered outputs. Combinational outputs keep their per-state values.
- **IDLE:**
  - `o_irq_bak`=2'b11, so banked r13 mirrors user r13 and banked r14 follows PC writes. This is harmless and is overwritten at entry.
  - Go to SAVE when `i_irq & i_irq_enable`.
- **SAVE:**
  - `o_irq_bak`=2'b01; `o_irq_r0`={zeros, `i_irq_id`}, so banked r0 latches the ID.
  - Go to LINK.
- **LINK:**
  - `o_irq_bak` = `i_pc_en` ? 2'b11 : 2'b10.
  - Banked r14 captures the redirect target if a branch is in flight, otherwise `pc_next`.
  - Banked r13 captures the current r13.
  - Go to ENTER.
- **ENTER:**
  - `o_flush`=1, `o_pc_load`=1, `o_pc_target`=VECTOR, `o_irq_ack`=1.
  - `o_int_mode` register is set.
  - Go to HANDLER.
- **HANDLER:**
  - `o_int_mode`=1; `o_irq_bak`=2'b11 (ignored by the register file in int mode).
  - `i_irq` is ignored: no nesting, and the request stays pending.
  - On `i_irq_ret`, capture `i_ret_addr` into `ret_q` and go to LEAVE.
- **LEAVE:**
  - `o_flush`=1, `o_pc_load`=1, `o_pc_target`=`ret_q`.
  - `o_int_mode` register is cleared.
  - Go to IDLE.
- **Outputs outside their active state:** `o_pc_load`, `o_flush` and `o_irq_ack` are 0. `o_pc_target` is 0. `o_irq_r0` holds its last value.
- **Mask dropping mid-sequence:** if `i_irq_enable` drops in SAVE or LINK, the sequence still completes. The backup is already partly written, so it is not aborted.
- **`i_irq` dropping before ENTER:** the sequence still completes and acks. The handler sees the ID in r0.
- **`i_irq_ret` outside HANDLER:** ignored.
- **Asynchronous reset, any state including mid-sequence:**
  - State goes to IDLE.
  - `o_int_mode`=0, `o_irq_bak`=2'b11, `o_irq_r0`=0, `o_pc_load`=0, `o_pc_target`=0, `o_flush`=0, `o_irq_ack`=0, `o_busy`=0, `ret_q`=0.

## Timing
- **Entry latency:** `i_irq` sampled high in IDLE at edge N gives SAVE in N+1, LINK in N+2, ENTER in N+3. `o_int_mode`=1 from N+4. All counts are in `i_en`-high cycles.
- **Stalls:** any `i_en`=0 cycle inserts one cycle of delay without skipping states.
- **Exit latency:** `i_irq_ret` at edge M gives LEAVE in M+1. `o_int_mode`=0 and IDLE from M+2.
- **Back-to-back requests:** an interrupt still pending on return is re-entered at the earliest 1 cycle after LEAVE (IDLE → SAVE).
- **Output timing:** `o_int_mode` and `ret_q` are registered. `o_irq_bak`, `o_pc_load`, `o_flush`, `o_irq_ack` and `o_pc_target` are decoded combinationally from state (and from `i_pc_en` in LINK).

## Test plan
- **Basic entry:** `i_irq`=1, `i_irq_id`=8'h05, `i_en`=1, no branch.
  - `o_irq_bak` sequence is 11, 01, 10, 11.
  - ENTER cycle shows `o_pc_target`=32'h18 with flush and ack.
  - Banked r0=5 and banked r14=`pc_next` at LINK.
  - `o_int_mode`=1 four cycles after the request.
- **Branch in LINK:** `i_pc_en`=1 in the LINK cycle with target 32'h100. Required: `o_irq_bak`=2'b11 and banked r14=32'h100.
- **Return:** in HANDLER, pulse `i_irq_ret` with `i_ret_addr`=32'h2004.
  - Next cycle: `o_pc_load`=1, target 32'h2004, flush.
  - The following cycle: `o_int_mode`=0, `o_busy`=0.
- **Masking and no nesting:**
  - `i_irq_enable`=0 with `i_irq`=1 → stays IDLE.
  - A second `i_irq` during HANDLER → no SAVE until after LEAVE, then re-entry begins.
- **Stall:** drop `i_en` for 3 cycles during LINK. State and `o_irq_bak` are held; ENTER occurs 3 cycles late.
- **Reset mid-sequence:** assert `rst_n`=0 in ENTER or HANDLER. All outputs return to their reset values immediately (asynchronously); the next request restarts from SAVE.

Source files
------------

// File: rtl/irq_sequencer_if.sv
// -----------------------------------------------------------------------------
// irq_sequencer_if
//   Interrupt-source side of the interrupt sequencer. It carries the level
//   request with its ID and global mask, the one-cycle acknowledge, and the
//   handler-return pulse with the saved return address.
//
//   Modports:
//     master - interrupt source / core side (drives request and return)
//     slave  - irq_sequencer (drives acknowledge)
//
//   Signals:
//     i_irq         level interrupt request, held until o_irq_ack
//     i_irq_id      ID of the requesting source (ID_W bits)
//     i_irq_enable  global interrupt mask, 1 = allowed
//     o_irq_ack     1-cycle acknowledge to the source
//     i_irq_ret     handler return instruction retired (1-cycle pulse)
//     i_ret_addr    return address, valid with i_irq_ret
// -----------------------------------------------------------------------------
interface irq_sequencer_if #(
  parameter int ID_W = 8
);
  logic            i_irq;
  logic [ID_W-1:0] i_irq_id;
  logic            i_irq_enable;
  logic            o_irq_ack;
  logic            i_irq_ret;
  logic [31:0]     i_ret_addr;

  modport master (
    output i_irq,
    output i_irq_id,
    output i_irq_enable,
    output i_irq_ret,
    output i_ret_addr,
    input  o_irq_ack
  );

  modport slave (
    input  i_irq,
    input  i_irq_id,
    input  i_irq_enable,
    input  i_irq_ret,
    input  i_ret_addr,
    output o_irq_ack
  );
endinterface : irq_sequencer_if

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
//   Interrupt entry/exit controller for the banked register file.
//
//   Entry:  IDLE -> SAVE (r0 <- ID) -> LINK (r13/r14 <- SP / return address)
//           -> ENTER (flush, jump to VECTOR, ack) -> HANDLER (int mode).
//   Exit:   HANDLER --i_irq_ret--> LEAVE (flush, jump to saved return) -> IDLE.
//   Every state move is qualified by i_en, so a stalled pipeline freezes the
//   state and all registered outputs.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     i_en           pipeline advance (register file en)
//     i_pc_en        a PC write is in flight this cycle
//     irq_bus        interrupt source handshake (slave modport)
//     o_int_mode     register file interrupt mode (registered)
//     o_irq_bak      register file banked-write select (combinational)
//     o_irq_r0       value for banked r0 (interrupt ID, zero-extended)
//     o_pc_load      force PC to o_pc_target
//     o_pc_target    redirect address
//     o_flush        kill younger in-flight instructions
//     o_busy         high in any state other than IDLE
// -----------------------------------------------------------------------------
module irq_sequencer #(
  parameter logic [31:0] VECTOR = 32'h0000_0018,
  parameter int          ID_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_pc_en,
  irq_sequencer_if.slave        irq_bus,
  output logic                  o_int_mode,
  output logic [1:0]            o_irq_bak,
  output logic [31:0]           o_irq_r0,
  output logic                  o_pc_load,
  output logic [31:0]           o_pc_target,
  output logic                  o_flush,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_LINK    = 3'd2,
    ST_ENTER   = 3'd3,
    ST_HANDLER = 3'd4,
    ST_LEAVE   = 3'd5
  } state_e;

  // Banked-write select encodings seen by the register file.
  localparam logic [1:0] BAK_NONE = 2'b11;  // mirror / follow, harmless
  localparam logic [1:0] BAK_R0   = 2'b01;  // banked r0 <- o_irq_r0
  localparam logic [1:0] BAK_LINK = 2'b10;  // banked r14 <- pc_next, r13 <- r13

  state_e      state_q, state_d;
  logic        int_mode_q, int_mode_d;
  logic [31:0] ret_q, ret_d;
  logic [31:0] r0_q, r0_d;
  logic [31:0] irq_id_ext;

  assign irq_id_ext = {{(32-ID_W){1'b0}}, irq_bus.i_irq_id};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (i_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (irq_bus.i_irq && irq_bus.i_irq_enable) state_d = ST_SAVE;
        end
        // Once SAVE is entered the backup is partly written; neither the mask
        // nor the request line can abort the sequence from here on.
        ST_SAVE:  state_d = ST_LINK;
        ST_LINK:  state_d = ST_ENTER;
        ST_ENTER: state_d = ST_HANDLER;
        // No nesting: a pending request waits until after LEAVE.
        ST_HANDLER: begin
          if (irq_bus.i_irq_ret) state_d = ST_LEAVE;
        end
        ST_LEAVE: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered datapath: interrupt mode, return address, last r0 value.
  // All of it only changes on i_en cycles so a stall freezes it.
  // ---------------------------------------------------------------------------
  always_comb begin
    int_mode_d = int_mode_q;
    ret_d      = ret_q;
    r0_d       = r0_q;
    if (i_en) begin
      case (state_q)
        ST_SAVE:    r0_d       = irq_id_ext;
        ST_ENTER:   int_mode_d = 1'b1;
        ST_HANDLER: if (irq_bus.i_irq_ret) ret_d = irq_bus.i_ret_addr;
        ST_LEAVE:   int_mode_d = 1'b0;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_mode_q <= 1'b0;
      ret_q      <= '0;
      r0_q       <= '0;
    end else begin
      int_mode_q <= int_mode_d;
      ret_q      <= ret_d;
      r0_q       <= r0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (combinational from state, plus i_pc_en in LINK)
  // ---------------------------------------------------------------------------
  always_comb begin
    o_irq_bak         = BAK_NONE;
    o_irq_r0          = r0_q;
    o_pc_load         = 1'b0;
    o_pc_target       = '0;
    o_flush           = 1'b0;
    irq_bus.o_irq_ack = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_SAVE: begin
        // Present the live ID so banked r0 captures it at the SAVE edge.
        o_irq_bak = BAK_R0;
        o_irq_r0  = irq_id_ext;
      end
      ST_LINK: begin
        // With a branch in flight, the "follow PC writes" select makes banked
        // r14 capture the branch target instead of the sequential pc_next.
        o_irq_bak = i_pc_en ? BAK_NONE : BAK_LINK;
      end
      ST_ENTER: begin
        o_pc_load         = 1'b1;
        o_pc_target       = VECTOR;
        o_flush           = 1'b1;
        irq_bus.o_irq_ack = 1'b1;
      end
      ST_HANDLER: ;
      ST_LEAVE: begin
        o_pc_load   = 1'b1;
        o_pc_target = ret_q;
        o_flush     = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_int_mode = int_mode_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule : irq_sequencer
